// File: rtl/vector_issue_sequencer_if.sv
// Handshake and bus bundle between vector decode, the issue sequencer and the functional units.
// master is the decode/FU side, slave is the sequencer.
interface vector_issue_sequencer_if #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned VL_W      = 8
);
    logic                 instr_valid;
    logic                 instr_ready;
    logic [2:0]           fu_type;
    logic [VL_W-1:0]      vl;
    logic [1:0]           sew;
    logic                 vd_widen;
    logic                 vd_narrow;
    logic                 vs2_widen;
    logic                 stall;
    logic                 flush;
    logic [6:0]           fu_ready;
    logic                 div_done;
    logic                 issue_valid;
    logic [6:0]           issue_fu;
    logic [VL_W-1:0]      issue_eidx;
    logic [NUM_LANES-1:0] issue_lane_mask;
    logic [2:0]           issue_vd_off;
    logic [2:0]           issue_vs2_off;
    logic [2:0]           issue_vs1_off;
    logic                 issue_last;
    logic                 busy;
    logic                 done;
    logic                 illegal;

    modport master (
        output instr_valid, fu_type, vl, sew, vd_widen, vd_narrow, vs2_widen,
               stall, flush, fu_ready, div_done,
        input  instr_ready, issue_valid, issue_fu, issue_eidx, issue_lane_mask,
               issue_vd_off, issue_vs2_off, issue_vs1_off, issue_last, busy, done, illegal
    );

    modport slave (
        input  instr_valid, fu_type, vl, sew, vd_widen, vd_narrow, vs2_widen,
               stall, flush, fu_ready, div_done,
        output instr_ready, issue_valid, issue_fu, issue_eidx, issue_lane_mask,
               issue_vd_off, issue_vs2_off, issue_vs1_off, issue_last, busy, done, illegal
    );
endinterface

// File: rtl/vector_issue_sequencer.sv
// Vector issue sequencer: walks one decoded instruction's element index in NUM_LANES groups
// and hands each group to the selected functional unit; the divider takes one group per completion.
module vector_issue_sequencer #(
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned VL_W       = 8,
    parameter int unsigned VLENB_LOG2 = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    vector_issue_sequencer_if.slave  bus
);
    localparam int unsigned VLX_W      = VL_W + 1;
    localparam logic [2:0]  FU_DIV     = 3'd2;
    localparam logic [2:0]  FU_ILLEGAL = 3'd7;

    typedef enum logic [1:0] {IDLE, ISSUE, DIV_WAIT, FIN} state_t;

    state_t               state;
    logic [VL_W-1:0]      eidx;
    logic [VL_W-1:0]      vl_r;
    logic [2:0]           fu_r;
    logic [1:0]           sew_r;
    logic                 vd_widen_r;
    logic                 vd_narrow_r;
    logic                 vs2_widen_r;
    logic                 last_sent;

    logic                 in_issue;
    logic                 fire;
    logic                 last_grp;
    logic [VLX_W-1:0]     next_idx_x;
    logic [6:0]           fu_oh;
    logic [NUM_LANES-1:0] lane_mask;
    logic [2:0]           vs2_sum;
    logic [2:0]           vd_sum;
    logic [1:0]           s_vs2;
    logic [1:0]           s_vd;

    // Register-group offset: which register of the group holds element idx at size code s.
    function automatic logic [2:0] reg_off(input logic [VL_W-1:0] idx, input logic [1:0] s);
        logic [VL_W-1:0] shifted;
        shifted = idx >> (VLENB_LOG2 - 32'(s));
        return shifted[2:0];
    endfunction

    assign in_issue   = (state == ISSUE);
    assign next_idx_x = {1'b0, eidx} + VLX_W'(NUM_LANES);
    assign last_grp   = (next_idx_x >= {1'b0, vl_r});

    always_comb begin
        fu_oh     = '0;
        lane_mask = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            fu_oh[i] = in_issue && (fu_r == 3'(i));
        end
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            lane_mask[i] = in_issue && (({1'b0, eidx} + VLX_W'(i)) < {1'b0, vl_r});
        end
    end

    // Element size codes: widening saturates at 64-bit, narrowing floors at 8-bit.
    always_comb begin
        vs2_sum = {1'b0, sew_r} + {2'b00, vs2_widen_r};
        s_vs2   = (vs2_sum > 3'd3) ? 2'd3 : vs2_sum[1:0];
        vd_sum  = {1'b0, sew_r} + {2'b00, vd_widen_r};
        if (vd_narrow_r && (vd_sum != 3'd0)) begin
            vd_sum = vd_sum - 3'd1;
        end
        s_vd    = (vd_sum > 3'd3) ? 2'd3 : vd_sum[1:0];
    end

    assign bus.instr_ready     = (state == IDLE) && !bus.flush;
    assign bus.issue_valid     = in_issue && !bus.stall && !bus.flush;
    assign bus.issue_fu        = fu_oh;
    assign bus.issue_eidx      = eidx;
    assign bus.issue_lane_mask = lane_mask;
    assign bus.issue_last      = in_issue && last_grp;
    assign bus.issue_vd_off    = reg_off(eidx, s_vd);
    assign bus.issue_vs2_off   = reg_off(eidx, s_vs2);
    assign bus.issue_vs1_off   = reg_off(eidx, sew_r);
    assign bus.busy            = (state != IDLE);
    assign bus.done            = (state == FIN);
    assign bus.illegal         = (state == FIN) && (fu_r == FU_ILLEGAL);

    assign fire = bus.issue_valid && ((fu_oh & bus.fu_ready) != 7'd0);

    // Sequencer state; flush outranks every transition, including an accept or a fire.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            eidx        <= '0;
            vl_r        <= '0;
            fu_r        <= '0;
            sew_r       <= '0;
            vd_widen_r  <= 1'b0;
            vd_narrow_r <= 1'b0;
            vs2_widen_r <= 1'b0;
            last_sent   <= 1'b0;
        end else if (bus.flush) begin
            state <= IDLE;
            eidx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.instr_valid) begin
                        fu_r        <= bus.fu_type;
                        vl_r        <= bus.vl;
                        sew_r       <= bus.sew;
                        vd_widen_r  <= bus.vd_widen;
                        vd_narrow_r <= bus.vd_narrow;
                        vs2_widen_r <= bus.vs2_widen;
                        eidx        <= '0;
                        last_sent   <= 1'b0;
                        if ((bus.fu_type == FU_ILLEGAL) || (bus.vl == '0)) begin
                            state <= FIN;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (fire) begin
                        eidx      <= eidx + VL_W'(NUM_LANES);
                        last_sent <= last_grp;
                        if (fu_r == FU_DIV) begin
                            state <= DIV_WAIT;
                        end else if (last_grp) begin
                            state <= FIN;
                        end
                    end
                end
                DIV_WAIT: begin
                    if (bus.div_done) begin
                        state <= last_sent ? FIN : ISSUE;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vector_issue_sequencer.sv
// Directed bench for vector_issue_sequencer: expected issue groups are queued when an instruction
// is sent and checked against each observed fire.
module tb_vector_issue_sequencer;
    localparam int unsigned NL  = 4;
    localparam int unsigned VW  = 8;
    localparam int unsigned VLB = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    vector_issue_sequencer_if #(.NUM_LANES(NL), .VL_W(VW)) bus ();

    vector_issue_sequencer #(.NUM_LANES(NL), .VL_W(VW), .VLENB_LOG2(VLB)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct {
        logic [6:0]    fu;
        logic [VW-1:0] eidx;
        logic [NL-1:0] mask;
        logic [2:0]    vd;
        logic [2:0]    vs2;
        logic [2:0]    vs1;
        logic          last;
    } grp_t;

    grp_t sb[$];
    grp_t mg;
    int   n_vec = 0;
    int   n_err = 0;
    int   fire_cnt = 0;
    int   cyc = 0;
    int   last_fire_cyc = -100;
    int   f0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int clamp3(input int v);
        return (v < 0) ? 0 : ((v > 3) ? 3 : v);
    endfunction

    // Register within the group = byte address of the element divided by the register size.
    function automatic logic [2:0] byte_reg(input int e, input int s);
        return 3'(((e * (1 << s)) / (1 << VLB)) % 8);
    endfunction

    task automatic push_instr(input int fu, input int vl, input int sew,
                              input int vdw, input int vdn, input int vs2w);
        grp_t g;
        int   svd;
        int   svs2;
        if (fu == 7) return;
        svd  = clamp3(sew + vdw - vdn);
        svs2 = clamp3(sew + vs2w);
        for (int e = 0; e < vl; e += NL) begin
            g.fu   = 7'(1 << fu);
            g.eidx = VW'(e);
            for (int i = 0; i < NL; i++) g.mask[i] = (e + i < vl);
            g.vd   = byte_reg(e, svd);
            g.vs2  = byte_reg(e, svs2);
            g.vs1  = byte_reg(e, sew);
            g.last = (e + NL >= vl);
            sb.push_back(g);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int fu, input int vl, input int sew,
                        input int vdw, input int vdn, input int vs2w);
        bus.instr_valid = 1'b1;
        bus.fu_type     = 3'(fu);
        bus.vl          = VW'(vl);
        bus.sew         = 2'(sew);
        bus.vd_widen    = 1'(vdw);
        bus.vd_narrow   = 1'(vdn);
        bus.vs2_widen   = 1'(vs2w);
        push_instr(fu, vl, sew, vdw, vdn, vs2w);
        @(negedge clk);
        chk("accept_ready", 32'(bus.instr_ready), 1);
        step();
        bus.instr_valid = 1'b0;
    endtask

    // Waits for done; lat>0 checks the negedge count after accept, gap checks done follows the last fire.
    task automatic wait_done(input string tag, input int budget, input int lat,
                             input int exp_ill, input bit gap);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (n < budget && !seen) begin
            @(negedge clk);
            n++;
            if (bus.done === 1'b1) seen = 1'b1;
            else step();
        end
        chk({tag, "_done_seen"}, 32'(seen), 1);
        if (seen) begin
            if (lat > 0) chk({tag, "_done_latency"}, 32'(n), 32'(lat));
            if (gap) chk({tag, "_done_after_last_fire"}, 32'(cyc - last_fire_cyc), 1);
            chk({tag, "_illegal"}, 32'(bus.illegal), 32'(exp_ill));
            chk({tag, "_no_issue_at_done"}, 32'(bus.issue_valid), 0);
            step();
            @(negedge clk);
            chk({tag, "_done_pulse_ends"}, 32'(bus.done), 0);
            chk({tag, "_ready_returns"}, 32'(bus.instr_ready), 1);
        end
        step();
    endtask

    // Scoreboard: every fire pops the next expected group.
    always @(negedge clk) begin
        if (!rst && bus.issue_valid === 1'b1 && (bus.issue_fu & bus.fu_ready) != 7'd0) begin
            fire_cnt++;
            last_fire_cyc = cyc;
            if (sb.size() == 0) begin
                chk("sb_unexpected_fire", 32'(bus.issue_eidx), 32'hFFFF);
            end else begin
                mg = sb.pop_front();
                chk("grp_fu",   32'(bus.issue_fu),        32'(mg.fu));
                chk("grp_eidx", 32'(bus.issue_eidx),      32'(mg.eidx));
                chk("grp_mask", 32'(bus.issue_lane_mask), 32'(mg.mask));
                chk("grp_vd",   32'(bus.issue_vd_off),    32'(mg.vd));
                chk("grp_vs2",  32'(bus.issue_vs2_off),   32'(mg.vs2));
                chk("grp_vs1",  32'(bus.issue_vs1_off),   32'(mg.vs1));
                chk("grp_last", 32'(bus.issue_last),      32'(mg.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.fu_type = '0;
        bus.vl = '0;
        bus.sew = '0;
        bus.vd_widen = 1'b0;
        bus.vd_narrow = 1'b0;
        bus.vs2_widen = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.fu_ready = '0;
        bus.div_done = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("rst_instr_ready", 32'(bus.instr_ready), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_issue_valid", 32'(bus.issue_valid), 0);
        chk("rst_issue_fu", 32'(bus.issue_fu), 0);
        chk("rst_eidx", 32'(bus.issue_eidx), 0);
        chk("rst_mask", 32'(bus.issue_lane_mask), 0);
        chk("rst_last", 32'(bus.issue_last), 0);
        chk("rst_offs", 32'({bus.issue_vd_off, bus.issue_vs2_off, bus.issue_vs1_off}), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_illegal", 32'(bus.illegal), 0);
        step();
        rst = 1'b0;
        bus.fu_ready = 7'h7F;

        // ARITH vl=10 sew=2: three back-to-back groups.
        f0 = fire_cnt;
        send(0, 10, 2, 0, 0, 0);
        wait_done("arith10", 20, 4, 0, 1'b1);
        chk("arith10_fires", 32'(fire_cnt - f0), 3);

        // MUL widening then narrowing destination.
        f0 = fire_cnt;
        send(1, 8, 1, 1, 0, 0);
        wait_done("mul_widen", 20, 3, 0, 1'b1);
        send(1, 8, 1, 0, 1, 0);
        wait_done("mul_narrow", 20, 3, 0, 1'b1);
        chk("mul_fires", 32'(fire_cnt - f0), 4);

        // ARITH vl=6 held off by fu_ready then by stall.
        f0 = fire_cnt;
        bus.fu_ready = 7'h7E;
        send(0, 6, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.issue_valid), 1);
            chk("hold_eidx", 32'(bus.issue_eidx), 0);
            chk("hold_mask", 32'(bus.issue_lane_mask), 32'h0F);
            chk("hold_fu", 32'(bus.issue_fu), 32'h01);
            chk("hold_last", 32'(bus.issue_last), 0);
            step();
        end
        bus.fu_ready = 7'h7F;
        bus.stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.issue_valid), 0);
            chk("stall_eidx", 32'(bus.issue_eidx), 0);
            step();
        end
        bus.stall = 1'b0;
        wait_done("stall6", 20, 0, 0, 1'b1);
        chk("stall6_fires", 32'(fire_cnt - f0), 2);

        // DIV vl=8: one group per div_done.
        f0 = fire_cnt;
        send(2, 8, 2, 0, 0, 0);
        @(negedge clk);
        chk("div_g0_valid", 32'(bus.issue_valid), 1);
        step();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("div_wait_valid", 32'(bus.issue_valid), 0);
            chk("div_wait_busy", 32'(bus.busy), 1);
            step();
        end
        bus.div_done = 1'b1;
        step();
        bus.div_done = 1'b0;
        @(negedge clk);
        chk("div_g1_eidx", 32'(bus.issue_eidx), 4);
        chk("div_g1_valid", 32'(bus.issue_valid), 1);
        step();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("div_wait2_valid", 32'(bus.issue_valid), 0);
            chk("div_wait2_done", 32'(bus.done), 0);
            step();
        end
        bus.div_done = 1'b1;
        step();
        bus.div_done = 1'b0;
        wait_done("div8", 5, 1, 0, 1'b0);
        chk("div8_fires", 32'(fire_cnt - f0), 2);

        // vl=0 and illegal unit: done without issue.
        f0 = fire_cnt;
        send(0, 0, 2, 0, 0, 0);
        wait_done("vl0", 5, 1, 0, 1'b0);
        send(7, 5, 2, 0, 0, 0);
        wait_done("illegal", 5, 1, 1, 1'b0);
        chk("noissue_fires", 32'(fire_cnt - f0), 0);

        // Flush during the second group of vl=12, then a fresh instruction.
        send(0, 12, 2, 0, 0, 0);
        @(negedge clk);
        step();
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_valid_forced", 32'(bus.issue_valid), 0);
        chk("flush_ready_low", 32'(bus.instr_ready), 0);
        step();
        bus.flush = 1'b0;
        sb.delete();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("flush_idle_busy", 32'(bus.busy), 0);
            chk("flush_no_done", 32'(bus.done), 0);
            chk("flush_ready", 32'(bus.instr_ready), 1);
            step();
        end
        send(0, 4, 2, 0, 0, 0);
        wait_done("after_flush", 10, 2, 0, 1'b1);

        // flush with instr_valid in IDLE: not accepted.
        bus.instr_valid = 1'b1;
        bus.fu_type = 3'd0;
        bus.vl = VW'(8);
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_accept_ready", 32'(bus.instr_ready), 0);
        step();
        bus.instr_valid = 1'b0;
        bus.flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("flush_accept_busy", 32'(bus.busy), 0);
            chk("flush_accept_valid", 32'(bus.issue_valid), 0);
            step();
        end

        // Reset in the middle of an instruction.
        bus.fu_ready = 7'h00;
        send(0, 12, 2, 0, 0, 0);
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_ready", 32'(bus.instr_ready), 1);
        chk("midrst_issue_fu", 32'(bus.issue_fu), 0);
        chk("midrst_eidx", 32'(bus.issue_eidx), 0);
        step();
        rst = 1'b0;
        sb.delete();
        bus.fu_ready = 7'h7F;
        step();

        chk("sb_drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vector_issue_sequencer.md
Name: vector_issue_sequencer

Overview:
- Sits between vector decode and the vector functional units (arith, mul, div, mask, perm, reduction, load/store).
- Accepts one decoded vector instruction at a time and walks its element index from 0 to vl-1 in groups of NUM_LANES.
- Issues each group to the selected unit with a valid/ready handshake, and supplies the register-group offsets for the vd/vs1/vs2 reads.
- The divider is serial: it receives one group per completion.

Parameters:
- NUM_LANES, 4, elements issued per group; must be a power of two.
- VL_W, 8, width of vl and of the element index.
- VLENB_LOG2, 4, log2 of the vector register length in bytes (VLEN=128).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- instr_valid  in  1  decoded instruction present.
- instr_ready  out  1  sequencer can accept an instruction.
- fu_type  in  3  unit select: 0 ARITH, 1 MUL, 2 DIV, 3 MASK, 4 PERM, 5 RED, 6 LS, 7 illegal.
- vl  in  VL_W  element count.
- sew  in  2  log2 of element bytes (0..3).
- vd_widen  in  1  destination element is 2*SEW.
- vd_narrow  in  1  destination element is SEW/2.
- vs2_widen  in  1  vs2 element is 2*SEW.
- stall  in  1  global stall; blocks issue.
- flush  in  1  abort the current instruction.
- fu_ready  in  7  per-unit ready, indexed by fu_type.
- div_done  in  1  divider finished its current group.
- issue_valid  out  1  group valid.
- issue_fu  out  7  one-hot target unit.
- issue_eidx  out  VL_W  element index of lane 0.
- issue_lane_mask  out  NUM_LANES  lane i active iff eidx+i < vl.
- issue_vd_off  out  3  vd register offset within the group.
- issue_vs2_off  out  3  vs2 register offset.
- issue_vs1_off  out  3  vs1 register offset.
- issue_last  out  1  final group of the instruction.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  one-cycle pulse for fu_type 7.

Behaviour:
- FSM states: IDLE, ISSUE, DIV_WAIT, FIN.
- Reset:
  - state=IDLE; eidx=0; all latched fields=0.
  - All outputs 0 except instr_ready=1.
- instr_ready = (state==IDLE) && !flush.
- Accept: on instr_valid && instr_ready, latch fu_type, vl, sew, vd_widen, vd_narrow, vs2_widen; eidx=0. Next state:
  - fu_type==7 → FIN with illegal pulse.
  - vl==0 → FIN.
  - otherwise → ISSUE.
- FIN: asserts done for one cycle, then → IDLE. No issue occurs for vl==0 or an illegal instruction. illegal is asserted in the same cycle as done.
- ISSUE outputs:
  - issue_valid = !stall.
  - issue_fu = one-hot(latched fu_type).
  - issue_eidx = eidx.
  - issue_last = (eidx+NUM_LANES >= vl), computed at VL_W+1 bits, no overflow.
- Fire = issue_valid && fu_ready[fu_type]. All issue_* outputs are held stable until fire.
- On fire:
  - eidx += NUM_LANES.
  - If last: → DIV_WAIT when DIV, else → FIN. done is asserted in the cycle after the final fire.
  - If not last: DIV → DIV_WAIT; others stay in ISSUE. Back-to-back issue is one group per cycle.
- DIV_WAIT:
  - issue_valid=0.
  - On div_done → ISSUE, or → FIN if the group sent was last.
  - div_done in any other state is ignored.
- Offsets:
  - Element size code: s_vs1 = sew; s_vs2 = min(sew+vs2_widen, 3); s_vd = min(sew+vd_widen-vd_narrow, 3), floored at 0.
  - off = eidx >> (VLENB_LOG2 - s), truncated to 3 bits.
  - Offsets are combinational from eidx and the latched fields.
- Flush:
  - Any state → IDLE next cycle; eidx=0; no done pulse.
  - issue_valid is forced 0 in the flush cycle.
  - A fire coinciding with flush is discarded.
  - flush with instr_valid in IDLE: the instruction is not accepted.
- stall:
  - Holds ISSUE with issue_valid=0.
  - Does not block the DIV_WAIT → ISSUE transition.
  - Does not block the FIN done pulse.
- Mid-operation RST: identical to reset values next cycle.
- Outputs are registered state plus combinational decode of state and eidx. There is no combinational path from fu_ready to instr_ready.

Test Plan:
- ARITH, vl=10, sew=2, fu_ready=all 1 → three consecutive fires:
  - eidx 0/4/8; masks 1111/1111/0011; vd_off 0/1/2.
  - issue_last on the third fire; done the next cycle; instr_ready returns.
- MUL, sew=1, vd_widen=1, vl=8 → two groups:
  - eidx 0 and 4 give vd_off 0 then 1 and vs2_off 0 then 0.
  - Repeat with vd_narrow=1, sew=1 → vd_off 0,0.
- ARITH, vl=6; hold fu_ready[0]=0 for 3 cycles, then stall=1 for 2 cycles.
  - issue_valid drops during stall.
  - eidx stays 0 and outputs stay stable until fire.
  - Total of 2 fires.
- DIV, vl=8:
  - One group issues, then DIV_WAIT with issue_valid=0.
  - div_done after 5 cycles → group eidx=4.
  - A second div_done → FIN, then done.
- vl=0 → no issue_valid, done one cycle after accept; fu_type=7 with vl=5 → illegal and done pulse together, no issue.
- Flush cases:
  - flush during the second group of vl=12 → IDLE next cycle, no done, instr_ready=1; a following instruction starts at eidx=0.
  - flush and instr_valid in the same cycle in IDLE → not accepted.
